// File: rtl/ahb_pkg.sv
// Shared AHB encodings, responder FSM states and default address window.
// Pure declarations; no timing or flow control of its own.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [31:0] AHB_BASE_LO = 32'h8000_0000;
    localparam logic [31:0] AHB_BASE_HI = 32'h8C00_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } ahb_state_t;

    // Window is half-open: lo inclusive, hi exclusive.
    function automatic logic in_window(input logic [31:0] addr,
                                       input logic [31:0] lo,
                                       input logic [31:0] hi);
        return (addr >= lo) && (addr < hi);
    endfunction

endpackage

// File: rtl/ahb_slave_mem.sv
// Word memory: one synchronous write port, one combinational read port.
// Write lands on the clock edge; read is same-cycle; reset clears every word.
module ahb_slave_mem #(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [31:0]      wr_dat,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [31:0]      rd_dat
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_vld) begin
            mem[wr_idx] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_idx];

endmodule

// File: rtl/ahb_slave_responder.sv
// Memory-backed AHB completer: data phase follows address phase, stretched by WAIT_STATES.
// Out-of-window transfers get a two-cycle ERROR; Hreadyout low holds the master's address phase.
module ahb_slave_responder
    import ahb_pkg::*;
#(
    parameter int          WAIT_STATES = 0,
    parameter int          DEPTH       = 16,
    parameter logic [31:0] BASE_LO     = AHB_BASE_LO,
    parameter logic [31:0] BASE_HI     = AHB_BASE_HI
) (
    input  logic        Hclk,
    input  logic        Hreset,
    input  logic        Hwrite,
    input  logic        Hreadyin,
    input  logic [1:0]  Htrans,
    input  logic [31:0] Haddr,
    input  logic [31:0] Hwdata,
    output logic [31:0] Hrdata,
    output logic        Hreadyout,
    output logic [1:0]  Hresp
);

    localparam int IDX_W = $clog2(DEPTH);

    ahb_state_t       state;
    logic [3:0]       wait_cnt;
    logic [IDX_W-1:0] lat_idx;
    logic             lat_write;

    logic             active;
    logic             accept;
    logic             addr_ok;
    logic             mem_wr_vld;
    logic [31:0]      mem_rd_dat;

    assign active  = (Htrans == HTRANS_NONSEQ) || (Htrans == HTRANS_SEQ);
    assign accept  = Hreadyin && Hreadyout && active;
    assign addr_ok = in_window(Haddr, BASE_LO, BASE_HI);

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            state     <= ST_IDLE;
            Hreadyout <= 1'b1;
            Hresp     <= HRESP_OKAY;
            wait_cnt  <= '0;
            lat_idx   <= '0;
            lat_write <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= ST_DATA;
                        Hreadyout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    Hreadyout <= 1'b1;
                    Hresp     <= HRESP_ERROR;
                end
                // IDLE, DATA and ERR2 all close with Hreadyout=1, so each may take a new address phase.
                default: begin
                    if (accept) begin
                        lat_idx   <= Haddr[IDX_W-1:0];
                        lat_write <= Hwrite;
                        if (!addr_ok) begin
                            state     <= ST_ERR1;
                            Hreadyout <= 1'b0;
                            Hresp     <= HRESP_ERROR;
                        end else if (WAIT_STATES == 0) begin
                            state     <= ST_DATA;
                            Hreadyout <= 1'b1;
                            Hresp     <= HRESP_OKAY;
                        end else begin
                            state     <= ST_WAIT;
                            Hreadyout <= 1'b0;
                            Hresp     <= HRESP_OKAY;
                            wait_cnt  <= 4'(WAIT_STATES - 1);
                        end
                    end else begin
                        state     <= ST_IDLE;
                        Hreadyout <= 1'b1;
                        Hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

    // ST_DATA is always the final, ready-high data cycle, so write data is taken only there.
    assign mem_wr_vld = (state == ST_DATA) && lat_write;

    ahb_slave_mem #(
        .DEPTH(DEPTH)
    ) u_mem (
        .clk    (Hclk),
        .rst    (Hreset),
        .wr_vld (mem_wr_vld),
        .wr_idx (lat_idx),
        .wr_dat (Hwdata),
        .rd_idx (lat_idx),
        .rd_dat (mem_rd_dat)
    );

    assign Hrdata = ((state == ST_WAIT || state == ST_DATA) && !lat_write) ? mem_rd_dat : 32'h0;

endmodule

// File: tb/tb_ahb_slave_responder.sv
// Three responders (0, 2 and 3 wait states), each with its own master, scoreboard and monitor.
module tb_ahb_slave_responder;

    localparam int          NL    = 3;
    localparam int          DEPTH = 16;
    localparam logic [31:0] LO    = 32'h8000_0000;
    localparam logic [31:0] HI    = 32'h8C00_0000;
    localparam logic [1:0]  TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NSEQ = 2'b10, TR_SEQ = 2'b11;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        logic [31:0] addr;
    } exp_t;

    logic hclk = 1'b0;
    always #5 hclk = ~hclk;

    int total = 0;
    int bad = 0;
    int lanes_done = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    for (genvar g = 0; g < NL; g++) begin : lane
        localparam int W = (g == 0) ? 0 : (g == 1) ? 2 : 3;

        logic        hreset   = 1'b1;
        logic        hwrite   = 1'b0;
        logic        hreadyin = 1'b1;
        logic [1:0]  htrans   = 2'b00;
        logic [31:0] haddr    = 32'h0;
        logic [31:0] hwdata   = 32'h0;
        logic [31:0] hrdata;
        logic        hreadyout;
        logic [1:0]  hresp;

        ahb_slave_responder #(
            .WAIT_STATES(W),
            .DEPTH      (DEPTH),
            .BASE_LO    (LO),
            .BASE_HI    (HI)
        ) dut (
            .Hclk     (hclk),
            .Hreset   (hreset),
            .Hwrite   (hwrite),
            .Hreadyin (hreadyin),
            .Htrans   (htrans),
            .Haddr    (haddr),
            .Hwdata   (hwdata),
            .Hrdata   (hrdata),
            .Hreadyout(hreadyout),
            .Hresp    (hresp)
        );

        exp_t        q[$];
        logic [31:0] model [DEPTH];
        bit          pend = 0;
        bit          resp_bad = 0;
        int          lowc = 0;
        exp_t        cur;

        // Master: hold the address phase until the slave is ready, then present write data.
        task automatic drive(input logic [1:0] tr, input logic [31:0] a, input logic wr,
                             input logic [31:0] wd, input logic rin);
            bit   rdy;
            int   n;
            exp_t e;
            n = 0;
            htrans = tr; haddr = a; hwrite = wr; hreadyin = rin;
            do begin
                @(negedge hclk);
                rdy = hreadyout;
                @(posedge hclk);
                #1;
                n++;
            end while (!rdy && n < 50);
            if (!rdy) check($sformatf("lane%0d accept timeout", g), 0, 1);
            if (tr[1] && rin) begin
                e.addr  = a;
                e.err   = !(a >= LO && a < HI);
                e.rdata = (!e.err && !wr) ? model[a % DEPTH] : 32'h0;
                if (!e.err && wr) model[a % DEPTH] = wd;
                q.push_back(e);
                hwdata = wd;
            end else begin
                hwdata = $urandom;
            end
            hreadyin = 1'b1;
        endtask

        always @(negedge hclk) begin
            if (hreset) begin
                pend = 0;
            end else begin
                if (pend) begin
                    if (q.size() == 0) begin
                        check($sformatf("lane%0d unexpected transfer", g), 1, 0);
                        pend = 0;
                    end else if (!hreadyout) begin
                        lowc++;
                        if (hresp !== (q[0].err ? 2'b01 : 2'b00)) resp_bad = 1;
                        if (lowc > 40) begin
                            check($sformatf("lane%0d stall timeout", g), lowc, 40);
                            cur = q.pop_front();
                            pend = 0;
                        end
                    end else begin
                        cur = q.pop_front();
                        check($sformatf("lane%0d waits @%h", g, cur.addr), lowc, cur.err ? 1 : W);
                        check($sformatf("lane%0d resp @%h", g, cur.addr), {resp_bad, hresp},
                              {1'b0, (cur.err ? 2'b01 : 2'b00)});
                        check($sformatf("lane%0d rdata @%h", g, cur.addr), hrdata, cur.rdata);
                        pend = 0;
                    end
                end else begin
                    check($sformatf("lane%0d idle outputs", g), {hreadyout, hresp, hrdata},
                          {1'b1, 2'b00, 32'h0});
                end
                if (!pend && htrans[1] && hreadyin && hreadyout) begin
                    pend = 1;
                    lowc = 0;
                    resp_bad = 0;
                end
            end
        end

        initial begin
            int          n;
            int          r;
            logic [1:0]  tr;
            logic [31:0] a;
            logic        w;
            for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
            repeat (2) @(negedge hclk);
            check($sformatf("lane%0d reset outputs", g), {hreadyout, hresp, hrdata}, {1'b1, 2'b00, 32'h0});
            @(posedge hclk);
            #1 hreset = 1'b0;

            // single write then burst
            drive(TR_NSEQ, 32'h8000_0001, 1, 32'h1234, 1);
            for (int i = 2; i <= 4; i++) drive(TR_SEQ, LO + i, 1, 32'h1233 + i, 1);
            drive(TR_IDLE, 0, 0, 0, 1);
            // read back through an aliasing address
            drive(TR_NSEQ, 32'h8000_4001, 0, 0, 1);
            for (int i = 2; i <= 4; i++) drive(TR_SEQ, LO + i, 0, 0, 1);
            // error write must not touch memory
            drive(TR_NSEQ, 32'h9000_0000, 1, 32'hDEAD, 1);
            drive(TR_NSEQ, 32'h8000_0000, 0, 0, 1);
            // back-to-back write/read of one word
            drive(TR_NSEQ, 32'h8000_0005, 1, 32'hABCD, 1);
            drive(TR_NSEQ, 32'h8000_0005, 0, 0, 1);
            // window edges
            drive(TR_NSEQ, LO - 1, 1, 32'h1111_0001, 1);
            drive(TR_NSEQ, LO, 1, 32'h1111_0002, 1);
            drive(TR_NSEQ, HI - 1, 1, 32'h1111_0003, 1);
            drive(TR_NSEQ, HI, 1, 32'h1111_0004, 1);
            drive(TR_NSEQ, 32'hFFFF_FFFF, 0, 0, 1);
            drive(TR_NSEQ, LO, 0, 0, 1);
            drive(TR_NSEQ, HI - 1, 0, 0, 1);
            // not-ready and BUSY address phases are ignored
            drive(TR_IDLE, 0, 0, 0, 1);
            drive(TR_NSEQ, LO + 6, 1, 32'h5555, 0);
            drive(TR_BUSY, LO + 6, 1, 32'h6666, 1);
            drive(TR_NSEQ, LO + 6, 0, 0, 1);

            for (int i = 0; i < 80; i++) begin
                r = $urandom_range(0, 9);
                tr = (r < 1) ? TR_IDLE : (r < 2) ? TR_BUSY : (r < 6) ? TR_NSEQ : TR_SEQ;
                if ($urandom_range(0, 9) < 8) a = LO + $urandom_range(0, HI - LO - 1);
                else if ($urandom_range(0, 1) == 0) a = $urandom_range(0, LO - 1);
                else a = HI + $urandom_range(0, 32'hFFFF_FFFF - HI);
                w = 1'($urandom_range(0, 1));
                drive(tr, a, w, $urandom, 1);
            end

            // reset while a write sits in its data phase
            drive(TR_IDLE, 0, 0, 0, 1);
            drive(TR_NSEQ, LO + 7, 1, 32'hBEEF, 1);
            htrans = TR_IDLE;
            #1 hreset = 1'b1;
            q.delete();
            for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
            #1 check($sformatf("lane%0d reset mid-transfer", g), {hreadyout, hresp, hrdata},
                     {1'b1, 2'b00, 32'h0});
            repeat (2) @(posedge hclk);
            #1 hreset = 1'b0;
            drive(TR_NSEQ, LO, 0, 0, 1);
            for (int i = 1; i < DEPTH; i++) drive(TR_SEQ, LO + i, 0, 0, 1);
            drive(TR_IDLE, 0, 0, 0, 1);
            drive(TR_IDLE, 0, 0, 0, 1);

            n = 0;
            while ((q.size() != 0 || pend) && n < 100) begin
                @(posedge hclk);
                n++;
            end
            if (q.size() != 0) check($sformatf("lane%0d drain", g), q.size(), 0);
            lanes_done++;
        end
    end

    initial begin
        int n;
        n = 0;
        while (lanes_done < NL && n < 20000) begin
            @(posedge hclk);
            n++;
        end
        if (lanes_done < NL) check("lanes finished", lanes_done, NL);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ahb_slave_responder.md
Name: ahb_slave_responder

Overview:
- AHB slave responder: the completer end for the AHB master stimulus driving the AHB2APB bridge; standalone memory-backed target for bring-up and for checking master timing.
- Decodes the bridge window, accepts NONSEQ/SEQ transfers, inserts programmable wait states, stores/returns data in a small word memory, gives two-cycle ERROR response for out-of-window addresses.

Parameters:
- WAIT_STATES, 0, Hreadyout-low cycles inserted in every OKAY data phase (0..15)
- DEPTH, 16, memory words; index = Haddr[$clog2(DEPTH)-1:0] (word-indexed, no byte lanes)
- BASE_LO, 32'h8000_0000, lowest valid address (inclusive)
- BASE_HI, 32'h8C00_0000, valid window upper bound (exclusive)

Ports:
- Hclk  input  1  system clock, all state on rising edge
- Hreset  input  1  asynchronous, active-high reset
- Hwrite  input  1  1=write, 0=read; sampled in address phase
- Hreadyin  input  1  bus ready; address phase accepted only when 1
- Htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- Haddr  input  32  transfer address
- Hwdata  input  32  write data, valid in data phase
- Hrdata  output  32  read data during read data phase
- Hreadyout  output  1  0 = extend data phase
- Hresp  output  2  00 OKAY, 01 ERROR

Behaviour:
- Reset (async assert, sync use on deassert): FSM=ST_IDLE, Hreadyout=1, Hresp=00, Hrdata=0, wait counter=0, pipeline regs cleared, all DEPTH words=0. Reset mid-transfer discards any pending write.
- Accept: at posedge with Hreadyin=1, Hreadyout=1, Htrans[1]=1: latch Haddr index, Hwrite, valid=(BASE_LO<=Haddr<BASE_HI). IDLE/BUSY or Hreadyin=0 -> nothing latched, OKAY zero-wait response.
- FSM states: ST_IDLE, ST_WAIT, ST_DATA, ST_ERR1, ST_ERR2.
- ST_IDLE: Hreadyout=1, Hresp=00. On accept: invalid -> ST_ERR1; valid and WAIT_STATES=0 -> ST_DATA; else -> ST_WAIT with counter=WAIT_STATES-1.
- ST_WAIT: Hreadyout=0, Hresp=00; counter decrements; at 0 -> ST_DATA. Htrans/Haddr ignored (master must hold).
- ST_DATA: Hreadyout=1, Hresp=00. Write: mem[idx]<=Hwdata at closing edge. New accept in same cycle is allowed (pipelined) and follows ST_IDLE rules; no accept -> ST_IDLE.
- ST_ERR1: Hreadyout=0, Hresp=01 -> ST_ERR2. ST_ERR2: Hreadyout=1, Hresp=01; accept allowed as in ST_IDLE. ERROR never writes memory.
- Latency: WAIT_STATES=0 -> data phase one cycle after address phase; each transfer occupies 1+WAIT_STATES data cycles.
- Hrdata: combinational mem[idx] when the latched transfer is a valid read in ST_WAIT/ST_DATA, else 32'h0. Write followed by read of same index: write commits at the edge opening the read data phase, so the read returns the new data; no bypass logic needed.
- Write data sampled only in the final (Hreadyout=1) data cycle.

Decomposition:
- Package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ, HRESP_OKAY/ERROR, FSM state enum, BASE_LO/BASE_HI defaults.
- Sub-module ahb_slave_mem: DEPTH x 32 array, one sync write port, one async read port, async-reset clear.

Test Plan:
- Single write, W=0: NONSEQ 0x8000_0001 Hwrite=1, next cycle Hwdata=0x1234 -> Hreadyout stays 1, Hresp=00, mem[1]=0x1234.
- Burst write, W=0: NONSEQ 0x8000_0001 then SEQ 0x8000_0002..4 with data 0x1234..0x1237 -> mem[1..4]=0x1234..0x1237, no stall.
- Read back, W=2: NONSEQ 0x8000_4001 Hwrite=0 after mem[1]=0x1234 -> Hreadyout low exactly 2 cycles, then Hrdata=0x1234 with Hreadyout=1.
- Error: NONSEQ 0x9000_0000 write 0xDEAD -> cycle1 Hreadyout=0 Hresp=01, cycle2 Hreadyout=1 Hresp=01, memory unchanged.
- Write-then-read same index back-to-back, W=0: write 0x8000_0005=0xABCD then read 0x8000_0005 -> Hrdata=0xABCD.
- Reset mid-wait: assert Hreset during ST_WAIT of write, W=3 -> outputs immediately Hreadyout=1, Hresp=00, Hrdata=0; mem all 0.
